// File: rtl/and_reduce_sched.sv
// Time-shares one external and8 gate between two requesters for WIDTH-bit all-ones/zero detect.
// Define AND_REDUCE_EARLY_EXIT_EN to finish as soon as a chunk reduces to 0.
module and_reduce_sched #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             inv0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             inv1,
    output logic             ack0,
    output logic             ack1,
    output logic [7:0]       and8_in,
    input  logic             and8_out,
    output logic             result,
    output logic             result_id,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam int unsigned CHUNKS = WIDTH / 8;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
        $error("WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic               inv_q, inv_d;
    logic               id_q, id_d;
    logic               res_q, res_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;

    logic               grant_id;
    logic [CHUNKS-1:0][7:0] op_chunks;

    assign op_chunks = op_q;
    // Pointer only matters when both requesters contend.
    assign grant_id  = (req0 && req1) ? ptr_q : req1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        op_d    = op_q;
        inv_d   = inv_q;
        id_d    = id_q;
        res_d   = res_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StBusy;
                    op_d    = grant_id ? data1 : data0;
                    inv_d   = grant_id ? inv1 : inv0;
                    id_d    = grant_id;
                    cnt_d   = '0;
                    acc_d   = 1'b1;
                    ptr_d   = ~grant_id;
                    ack0_d  = ~grant_id;
                    ack1_d  = grant_id;
                end
            end
            StBusy: begin
                acc_d = acc_q & and8_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = StDone;
                    res_d   = acc_d;
                    cnt_d   = '0;
                end
`ifdef AND_REDUCE_EARLY_EXIT_EN
                if (!and8_out) begin
                    state_d = StDone;
                    res_d   = 1'b0;
                    cnt_d   = '0;
                end
`endif
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 1'b1;
            op_q    <= '0;
            inv_q   <= 1'b0;
            id_q    <= 1'b0;
            res_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            inv_q   <= inv_d;
            id_q    <= id_d;
            res_q   <= res_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign and8_in      = (state_q == StBusy) ? (op_chunks[cnt_q] ^ {8{inv_q}}) : 8'h00;
    assign result       = res_q;
    assign result_id    = id_q;
    assign result_valid = (state_q == StDone);
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_and_reduce_sched.sv
// Self-checking bench for and_reduce_sched: directed vector table, reset abort, random traffic.
module tb_and_reduce_sched;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNKS = WIDTH / 8;

    logic             clk;
    logic             rst_n;
    logic             req0, req1, inv0, inv1;
    logic [WIDTH-1:0] data0, data1;
    logic             ack0, ack1;
    logic [7:0]       and8_in;
    logic             and8_out;
    logic             result, result_id, result_valid, result_ready, busy;

    and_reduce_sched #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .data0        (data0),
        .inv0         (inv0),
        .req1         (req1),
        .data1        (data1),
        .inv1         (inv1),
        .ack0         (ack0),
        .ack1         (ack1),
        .and8_in      (and8_in),
        .and8_out     (and8_out),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    // External and8 reduction cell.
    assign and8_out = &and8_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_ptr;

    typedef struct {
        bit          r0;
        bit          r1;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          i0;
        bit          i1;
        int          hold;
        bit          exp_id;
        bit          exp_res;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_result(input logic [31:0] d, input bit inv);
        return inv ? (d == 32'h0) : (d == 32'hFFFF_FFFF);
    endfunction

    function automatic int model_latency(input logic [31:0] d, input bit inv);
`ifdef AND_REDUCE_EARLY_EXIT_EN
        logic [31:0] eff;
        eff = inv ? ~d : d;
        for (int c = 0; c < int'(CHUNKS); c++) begin
            if (eff[8*c +: 8] != 8'hFF) return c + 1;
        end
`endif
        return CHUNKS;
    endfunction

    task automatic scramble();
        data0 = $urandom;
        data1 = $urandom;
        inv0  = 1'($urandom);
        inv1  = 1'($urandom);
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic transact(input vec_t v);
        logic [31:0] od;
        bit          oi;
        int          lat;
        logic [7:0]  exp_chunk;
        req0 = v.r0; req1 = v.r1;
        data0 = v.d0; data1 = v.d1;
        inv0 = v.i0; inv1 = v.i1;
        od = v.exp_id ? v.d1 : v.d0;
        oi = v.exp_id ? v.i1 : v.i0;
        lat = model_latency(od, oi);
        model_ptr = ~v.exp_id;
        chk("and8_in_idle", and8_in, 8'h00);
        @(posedge clk); @(negedge clk);
        chk("ack0_grant", ack0, !v.exp_id);
        chk("ack1_grant", ack1, v.exp_id);
        chk("busy_grant", busy, 1'b1);
        if (v.exp_id) req1 = 1'b0; else req0 = 1'b0;
        scramble();
        for (int c = 0; c < lat; c++) begin
            if (c > 0) chk("ack_single_pulse", ack0 | ack1, 1'b0);
            exp_chunk = od[8*c +: 8] ^ {8{oi}};
            chk("and8_in_chunk", and8_in, exp_chunk);
            chk("valid_early", result_valid, 1'b0);
            @(posedge clk); @(negedge clk);
            scramble();
        end
        chk("valid_rise", result_valid, 1'b1);
        chk("result", result, v.exp_res);
        chk("result_id", result_id, v.exp_id);
        chk("busy_done", busy, 1'b1);
        chk("and8_in_done", and8_in, 8'h00);
        chk("ack_in_done", ack0 | ack1, 1'b0);
        for (int h = 0; h < v.hold; h++) begin
            req0 = 1'b1; req1 = 1'b1;
            @(posedge clk); @(negedge clk);
            chk("hold_valid", result_valid, 1'b1);
            chk("hold_result", result, v.exp_res);
            chk("hold_id", result_id, v.exp_id);
            chk("hold_busy", busy, 1'b1);
            chk("hold_no_ack", ack0 | ack1, 1'b0);
        end
        result_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        result_ready = 1'b0;
        chk("accept_valid", result_valid, 1'b0);
        chk("accept_busy", busy, 1'b0);
        chk("accept_no_ack", ack0 | ack1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] d;
        case ($urandom_range(0, 4))
            0: d = $urandom;
            1: d = 32'hFFFF_FFFF;
            2: d = 32'h0;
            3: d = ~(32'h1 << $urandom_range(0, 31));
            default: d = 32'h1 << $urandom_range(0, 31);
        endcase
        return d;
    endfunction

    initial begin
        vec_t v;
        tbl[0] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 32'hFFFF_7FFF, 32'h0000_0000, 1'b0, 1'b1, 3, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'hFFFF_7FFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 32'hFFFF_7FFF, 32'h0000_0000, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0100, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 32'h0000_00FE, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0, 1'b0};

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; result_ready = 1'b0;
        data0 = '0; data1 = '0; inv0 = 1'b0; inv1 = 1'b0;
        model_ptr = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_ack1", ack1, 1'b0);
        chk("rst_and8_in", and8_in, 8'h00);
        chk("rst_result", result, 1'b0);
        chk("rst_result_id", result_id, 1'b0);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i]) transact(tbl[i]);

        // Abort mid-operation with cnt=2.
        req0 = 1'b1; req1 = 1'b0; data0 = 32'hFFFF_FFFF; inv0 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort_ack0", ack0, 1'b1);
        req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("abort_chunk2", and8_in, 8'hFF);
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_and8_in", and8_in, 8'h00);
        chk("abort_valid", result_valid, 1'b0);
        chk("abort_ack", ack0 | ack1, 1'b0);
        chk("abort_result", result, 1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("abort_no_result", result_valid, 1'b0);
        chk("abort_no_ack", ack0 | ack1, 1'b0);
        rst_n = 1'b1;
        model_ptr = 1'b0;
        v = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        transact(v);

        for (int n = 0; n < 60; n++) begin
            v.r0 = 1'($urandom);
            v.r1 = 1'($urandom);
            if (!v.r0 && !v.r1) v.r1 = 1'b1;
            v.d0 = rand_operand();
            v.d1 = rand_operand();
            v.i0 = 1'($urandom);
            v.i1 = 1'($urandom);
            v.hold = $urandom_range(0, 3);
            v.exp_id = (v.r0 && v.r1) ? model_ptr : v.r1;
            v.exp_res = v.exp_id ? model_result(v.d1, v.i1) : model_result(v.d0, v.i0);
            transact(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    always @(negedge clk) begin
        if (ack0 && ack1) begin
            errors++;
            $display("FAIL dual_ack: got ack0=%0b ack1=%0b expected not both", ack0, ack1);
        end
    end

endmodule

// File: doc/and_reduce_sched.md
Name: and_reduce_sched

Overview:
- Controller that time-shares one external 8-input AND gate (the and8 reduction cell) between two requesters.
- Each request reduces a WIDTH-bit operand to one bit: either AND-reduce (all-ones detect) or AND-reduce of the inverted operand (zero detect).
- The operand is fed to the gate 8 bits per cycle, and the partial results are accumulated.
- Sits beside the ALU/branch logic wherever wide flag detection would otherwise need duplicated gate trees.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 8 and at least 8. CHUNKS = WIDTH/8 is derived internally.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request; held high until ack0 is seen.
- data0  input  WIDTH  requester 0 operand.
- inv0  input  1  requester 0 mode: 1 = zero detect (invert operand), 0 = all-ones detect.
- req1, data1, inv1  input  1/WIDTH/1  same as above, for requester 1.
- ack0  output  1  one-cycle pulse: requester 0's operand was latched.
- ack1  output  1  one-cycle pulse: requester 1's operand was latched.
- and8_in  output  8  chunk driven to the external and8 gate.
- and8_out  input  1  result returned by the external gate (combinational, same cycle).
- result  output  1  reduction result.
- result_id  output  1  index of the requester that owns result.
- result_valid  output  1  result is valid; held until result_ready.
- result_ready  input  1  consumer accepts the result.
- busy  output  1  high in states BUSY and DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, round-robin pointer=0 (requester 0 preferred), chunk counter=0, accumulator=1.
  - All outputs 0: ack0, ack1, and8_in, result, result_id, result_valid, busy.
- Reset asserted mid-operation aborts immediately. No ack or result is produced for the aborted request; the requester must re-request.
- IDLE:
  - Rising edge with any req high: grant and move to BUSY.
  - If both req are high, the pointer decides which is granted. If only one is high, it is granted.
  - On grant: latch the granted data/inv, set result_id, cnt=0, acc=1, and set the pointer to the non-granted requester.
  - The matching ack is registered high for exactly the cycle after the grant edge.
- BUSY:
  - and8_in = latched operand bits [8*cnt+7 : 8*cnt], inverted if the latched inv=1. This is combinational from registers.
  - Each edge: acc <= acc & and8_out, cnt <= cnt+1.
  - At the edge that samples chunk CHUNKS-1, go to DONE with result = final acc.
- DONE:
  - result_valid=1; result and result_id stay stable.
  - Edge with result_ready=1: go to IDLE and clear result_valid.
  - A new request can be granted no earlier than the following edge; there is no grant from DONE.
- and8_in = 0 outside BUSY.
- Latency: grant at edge E0, result_valid rises after edge E(CHUNKS). For WIDTH=32 that is 5 edges.
- Changes to req, data or inv after the grant have no effect on the request in flight.
- A req held high past its ack is treated as a new request once the block returns to IDLE.
- Counter width is ceil(log2(CHUNKS)), minimum 1 bit. It never wraps mid-operation.

Optional Feature:
- Macro: AND_REDUCE_EARLY_EXIT_EN.
- When defined: in BUSY, a sampled and8_out=0 moves the block straight to DONE with result=0, skipping the remaining chunks. The minimum latency is 1 BUSY edge.
- When undefined: all CHUNKS chunks are always processed, giving a fixed latency.
- The result value is identical in both cases.

Test Plan:
- All-ones detect: WIDTH=32, req0=1, data0=32'hFFFF_FFFF, inv0=0.
  - Expect ack0 pulse after E0; and8_in=FF for 4 cycles; result_valid after E4 with result=1, result_id=0.
- Zero detect: req1=1, data1=0, inv1=1.
  - Expect ack1; and8_in=FF each chunk; result=1, result_id=1.
- Single clear bit: data0=32'hFFFF_7FFF, inv0=0.
  - Macro undefined: result=0, valid after E4.
  - Macro defined: valid after E2 (chunk 1 = 8'h7F), result=0.
- Arbitration: req0=req1=1 from reset.
  - First grant goes to 0. After DONE is accepted, 1 is granted.
  - Third contest goes to 0.
  - No cycle has ack0 and ack1 high together.
- Backpressure: result_ready=0 for 3 cycles after valid.
  - result, result_id and result_valid are held stable; busy=1; a new req is not acked until 1 cycle after result_ready=1.
- Reset mid-op: drop rst_n during cnt=2.
  - All outputs 0 immediately, no ack or result produced.
  - After release with req1 and req0 both high, req0 is granted first.
